// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch/issue front end of the 8-bit core
// Fetches at the PC, offers ALU ops to execute, and steers the PC once per instruction.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  add,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  im,
  output logic               nia,
  output logic               branch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               ex_busy,
  input  logic               zf,
  output logic               halted
);

  typedef enum logic [1:0] {S_REQ, S_ISSUE, S_HALT} state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_SEQ, PC_JABS, PC_JREL} pc_op_t;

  state_t             state;
  state_t             state_nxt;
  pc_op_t             pc_op;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         opcode;
  logic               br_taken;

  assign opcode    = ir[INSTR_W-1 -: 4];
  assign br_taken  = (opcode == 4'hD) ? zf : !zf;
  assign mem_addr  = add;
  assign out_instr = ir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      ir     <= '0;
      out_pc <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ && mem_ack) begin
        ir     <= mem_rdata;
        out_pc <= add;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (mem_ack) state_nxt = S_ISSUE;
      S_ISSUE: begin
        case (opcode)
          4'hD, 4'hE: if (!ex_busy) state_nxt = S_REQ;
          4'hF:       state_nxt = S_HALT;
          4'h0, 4'hC: state_nxt = S_REQ;
          default:    if (out_ready) state_nxt = S_REQ;
        endcase
      end
      default: state_nxt = state;
    endcase
  end

  // Everything is gated by rst so a reset withdraws requests and offers in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    pc_op     = PC_HOLD;
    if (!rst) begin
      case (state)
        S_REQ:   mem_req = 1'b1;
        S_ISSUE: begin
          case (opcode)
            4'h0:       pc_op = PC_SEQ;
            4'hC:       pc_op = PC_JABS;
            4'hD, 4'hE: if (!ex_busy) pc_op = br_taken ? PC_JREL : PC_SEQ;
            4'hF:       pc_op = PC_HOLD;
            default: begin
              out_valid = 1'b1;
              if (out_ready) pc_op = PC_SEQ;
            end
          endcase
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  always_comb begin
    nia    = 1'b1;
    branch = 1'b0;
    im     = '0;
    case (pc_op)
      PC_SEQ: begin
        nia    = 1'b0;
        branch = 1'b1;
      end
      PC_JABS: begin
        nia    = 1'b0;
        branch = 1'b0;
        im     = ir[ADDR_W-1:0];
      end
      PC_JREL: begin
        nia    = 1'b1;
        branch = 1'b1;
        im     = ir[ADDR_W-1:0];
      end
      default: im = '0;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
// Includes a PC register and a variable-latency instruction memory around the DUT.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  add = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [7:0]  im;
  logic        nia;
  logic        branch;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        ex_busy = 1'b0;
  logic        zf = 1'b0;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;
  int ack_lat = 0;
  int wait_cnt = 0;
  logic [15:0] mem [256];
  logic [7:0]  exp_fetch [$];
  logic [9:0]  exp_ctrl  [$];
  logic [23:0] exp_issue [$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .add(add),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .im(im), .nia(nia), .branch(branch),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .ex_busy(ex_busy), .zf(zf), .halted(halted)
  );

  assign mem_ack   = mem_req && (wait_cnt >= ack_lat);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (rst) add <= 8'h00;
    else begin
      case ({nia, branch})
        2'b01:   add <= add + 8'd1;
        2'b00:   add <= im;
        2'b11:   add <= add + im;
        default: add <= add;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, want nothing", name, act);
  endtask

  task automatic wait_fetch(input logic [7:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      hit = mem_req && mem_ack && (mem_addr == a);
    end
    if (!hit) miss("fetch_timeout", 32'(a));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        if (exp_fetch.size() == 0) miss("fetch_extra", 32'(mem_addr));
        else chk("fetch_addr", 32'(mem_addr), 32'(exp_fetch.pop_front()));
      end
      if ({nia, branch} != 2'b10) begin
        if (exp_ctrl.size() == 0) miss("pc_ctrl_extra", 32'({nia, branch, im}));
        else chk("pc_ctrl", 32'({nia, branch, im}), 32'(exp_ctrl.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_issue.size() == 0) miss("issue_extra", 32'({out_instr, out_pc}));
        else chk("issue", 32'({out_instr, out_pc}), 32'(exp_issue.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, want end of sequence");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'h2155; mem[8'h02] = 16'hC010;
    mem[8'h10] = 16'hC03A; mem[8'h3A] = 16'hC020; mem[8'h20] = 16'hD0FE;
    mem[8'h1E] = 16'hC020; mem[8'h21] = 16'hE003; mem[8'h24] = 16'hC0FF;
    mem[8'hFF] = 16'h0000;
    // {nia, branch, im}: SEQ=0x100, JABS=0x0ii, JREL=0x3ii
    exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h3A, 8'h20, 8'h1E, 8'h20, 8'h21, 8'h24, 8'hFF, 8'h00};
    exp_ctrl  = '{10'h100, 10'h100, 10'h010, 10'h03A, 10'h020, 10'h3FE,
                  10'h020, 10'h100, 10'h303, 10'h0FF, 10'h100};
    exp_issue = '{24'h123400, 24'h215501};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ctrl", 32'({nia, branch, im}), 32'h200);
    chk("rst_out_instr", 32'(out_instr), 32'h0);
    chk("rst_out_pc", 32'(out_pc), 32'h0);
    rst = 1'b0;

    @(negedge clk);
    chk("c1_mem_req", 32'(mem_req), 32'd1);
    chk("c1_mem_addr", 32'(mem_addr), 32'h00);
    @(posedge clk); #1 ack_lat = 3;
    @(negedge clk);
    chk("c2_out_valid", 32'(out_valid), 32'd1);
    chk("c2_out_instr", 32'(out_instr), 32'h1234);
    chk("c2_ctrl", 32'({nia, branch, im}), 32'h100);
    @(posedge clk); #1 out_ready = 1'b0;

    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) n++;
      if (mem_req && mem_ack) break;
    end
    chk("ack_wait_req_cycles", 32'(n), 32'd4);
    @(posedge clk); #1 ack_lat = 0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_instr", 32'(out_instr), 32'h2155);
      chk("stall_ctrl_hold", 32'({nia, branch, im}), 32'h200);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    mem[8'h00] = 16'hF000;

    wait_fetch(8'h20);
    @(posedge clk); #1 ex_busy = 1'b1; zf = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("brz_busy_hold", 32'({nia, branch, im}), 32'h200);
      chk("brz_busy_no_req", 32'(mem_req), 32'd0);
    end
    @(posedge clk); #1 ex_busy = 1'b0; zf = 1'b1;

    wait_fetch(8'h20);
    @(posedge clk); #1 zf = 1'b0;

    wait_fetch(8'h00);
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_no_req", 32'(mem_req), 32'd0);
      chk("halt_ctrl_hold", 32'({nia, branch, im}), 32'h200);
    end

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_clears_halted", 32'(halted), 32'd0);
    ack_lat = 5;
    rst = 1'b0;
    @(negedge clk);
    chk("resume_mem_req", 32'(mem_req), 32'd1);
    chk("resume_mem_addr", 32'(mem_addr), 32'h00);
    chk("resume_halted", 32'(halted), 32'd0);
    @(negedge clk);
    chk("pending_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_drops_req", 32'(mem_req), 32'd0);
    chk("rst_drops_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);

    chk("fetch_q_left", 32'(exp_fetch.size()), 32'd0);
    chk("ctrl_q_left", 32'(exp_ctrl.size()), 32'd0);
    chk("issue_q_left", 32'(exp_issue.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch/decode front end of the 8-bit core, directly upstream of the program counter. Reads the instruction at the PC address from instruction memory over a req/ack handshake and latches it. Issues ALU instructions to the execute stage over a valid/ready handshake. Drives the PC's `im`/`nia`/`branch` controls so that the PC advances, jumps or holds exactly once per retired instruction.

## Interface
- ADDR_W, 8, instruction address width; equals the PC width.
- INSTR_W, 16, instruction width. Fields: [15:12] opcode, [11:8] rd/aux, [7:0] imm.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- add  in  ADDR_W  current PC value (PC output).
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  ADDR_W  read address; equals `add` while mem_req=1.
- mem_ack  in  1  read complete; mem_rdata valid this cycle. May assert in the same cycle as mem_req.
- mem_rdata  in  INSTR_W  instruction word.
- im  out  ADDR_W  PC immediate: absolute target or relative offset.
- nia  out  1  PC mode select.
- branch  out  1  PC mode qualifier.
- out_valid  out  1  instruction offered to execute.
- out_ready  in  1  execute accepts.
- out_instr  out  INSTR_W  latched instruction (IR).
- out_pc  out  ADDR_W  address the IR was fetched from.
- ex_busy  in  1  execute has instructions in flight; zf not yet final.
- zf  in  1  zero flag from execute.
- halted  out  1  HALT retired.

## Operation
- PC control encodings, combinational from state, IR and flags:
  - HOLD: nia=1, branch=0, im=0.
  - SEQ: nia=0, branch=1, im=0. PC becomes add+1, wrapping 0xFF→0x00.
  - JABS: nia=0, branch=0, im=ir[7:0].
  - JREL: nia=1, branch=1, im=ir[7:0]. Two's-complement offset; add+im mod 256.
- Default encoding is HOLD in every state and cycle not listed below.
- States: REQ, ISSUE, HALT.
- REQ:
  - mem_req=1, mem_addr=add.
  - On mem_ack: IR<=mem_rdata, out_pc<=add, go to ISSUE.
  - Without mem_ack: stay in REQ, request held.
- ISSUE, by opcode:
  - 0x0 NOP: SEQ, go to REQ. Not sent to execute.
  - 0x1–0xB ALU: out_valid=1. When out_ready=1, drive SEQ and go to REQ. Otherwise HOLD; out_valid and out_instr stay stable.
  - 0xC JMP: JABS, go to REQ.
  - 0xD BRZ: while ex_busy=1, HOLD. Once ex_busy=0, drive JREL if zf=1, else SEQ; go to REQ.
  - 0xE BRNZ: as BRZ with the condition inverted (JREL when zf=0).
  - 0xF HALT: HOLD, go to HALT.
- HALT: halted=1, HOLD, no requests. Exits only via rst.
- out_valid=1 only in ISSUE with an ALU opcode.
- Each instruction produces exactly one non-HOLD encoding, in the cycle it leaves ISSUE.

## Timing
- Reset: on the first edge with rst=1, state<=REQ, IR<=0, out_pc<=0.
- While rst=1: mem_req=0, out_valid=0, HOLD, halted=0.
- The first request is in the first cycle after rst falls.
- rst mid-operation, in any state, behaves identically:
  - A pending fetch is abandoned.
  - Memory must drop mem_ack when mem_req drops.
  - A pending execute offer is withdrawn.
- Minimum throughput, zero-wait memory (ack in the request cycle): 2 cycles per instruction. REQ cycle, then ISSUE cycle, in which the PC updates at the edge ending ISSUE.
- Each cycle of memory wait, out_ready=0 or ex_busy=1 (branches) adds one cycle.
- zf is sampled in the ISSUE cycle where ex_busy=0; zf values in earlier cycles are ignored.
- mem_rdata is captured only on the mem_ack edge in REQ. Stray mem_ack in other states is ignored.

## Test plan
- Reset, then zero-wait memory returning 0x1234 at 0x00 with out_ready=1:
  - mem_req in cycle 1 with mem_addr=0x00.
  - out_valid and out_instr=0x1234 in cycle 2, with SEQ.
  - Next mem_addr=0x01.
- Memory ack delayed 3 cycles, then ALU op with out_ready low 2 cycles:
  - mem_req held 4 cycles; out_instr stable while out_valid=1.
  - HOLD until the accept cycle; exactly one SEQ.
- JMP 0xC0_3A at add=0x10 → JABS with im=0x3A; next mem_addr=0x3A.
- BRZ 0xD0_FE at add=0x20 with ex_busy=1 for 2 cycles, then zf=1:
  - HOLD for 2 cycles, then JREL with im=0xFE; next mem_addr=0x1E.
  - Repeat with zf=0: SEQ; next mem_addr=0x21.
- Wrap: NOP at add=0xFF → SEQ; next mem_addr=0x00.
- HALT 0xF000:
  - halted=1, no further mem_req, HOLD indefinitely.
  - rst for 1 cycle → halted=0, fetch resumes at add=0x00.
  - rst asserted during a pending fetch → mem_req=0 the same cycle.
